// File: rtl/pc_pkg.sv
// pc_pkg: shared encodings, FSM state type and default addresses for the fetch PC unit.
//   NPC_*       : npc_sel encodings (any 1xx value is treated as sequential)
//   state_e     : RUN (normal fetch) / HOLD (redirect buffered while fetch blocked)
//   DEF_*       : default reset, exception-entry and legal instruction-memory addresses
package pc_pkg;
    localparam logic [2:0] NPC_SEQ = 3'b000;
    localparam logic [2:0] NPC_BR  = 3'b001;
    localparam logic [2:0] NPC_J   = 3'b010;
    localparam logic [2:0] NPC_JR  = 3'b011;

    typedef enum logic {RUN, HOLD} state_e;

    localparam logic [31:0] DEF_RESET_ADDR = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_ADDR   = 32'h0000_4180;
    localparam logic [31:0] DEF_IMEM_LO    = 32'h0000_3000;
    localparam logic [31:0] DEF_IMEM_HI    = 32'h0000_6FFC;
endpackage

// File: rtl/npc_calc.sv
// npc_calc: combinational next-PC target mux.
//   pc_f_i        : current fetch PC (sequential successor source)
//   pc_d_i        : PC of the control-transfer instruction in decode
//   imm16_i       : signed word offset for branches
//   instr_index_i : j/jal target field
//   rs_val_i      : jr target
//   npc_sel_i     : target select
//   target_o      : selected target address
//   redirect_o    : selection is a control transfer (branch, j/jal, jr)
module npc_calc
    import pc_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_f_i,
    input  logic [ADDR_W-1:0] pc_d_i,
    input  logic [15:0]       imm16_i,
    input  logic [25:0]       instr_index_i,
    input  logic [ADDR_W-1:0] rs_val_i,
    input  logic [2:0]        npc_sel_i,
    output logic [ADDR_W-1:0] target_o,
    output logic              redirect_o
);
    logic [ADDR_W-1:0] seq, pc_d4, br, jmp;

    assign seq   = pc_f_i + ADDR_W'(4);
    assign pc_d4 = pc_d_i + ADDR_W'(4);
    assign br    = pc_d4 + {{(ADDR_W-18){imm16_i[15]}}, imm16_i, 2'b00};
    assign jmp   = {pc_d4[ADDR_W-1:28], instr_index_i, 2'b00};

    assign redirect_o = npc_sel_i == NPC_BR || npc_sel_i == NPC_J || npc_sel_i == NPC_JR;
    assign target_o   = npc_sel_i == NPC_BR ? br :
                        npc_sel_i == NPC_J  ? jmp :
                        npc_sel_i == NPC_JR ? rs_val_i : seq;
endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage PC generator with redirect buffering, exception entry/return and fetch-address checking.
//   clk, reset          : clock, synchronous active-high reset
//   stall_i             : hazard hold of pc_f
//   imem_ready_i        : instruction memory accepts pc_f this cycle
//   npc_sel_i           : 000 seq, 001 branch, 010 j/jal, 011 jr, 1xx seq
//   pc_d_i, imm16_i, instr_index_i, rs_val_i : target operands from decode
//   exc_req_i, eret_req_i, epc_i             : exception entry / return
//   pc_f_o              : fetch PC
//   fetch_valid_o       : pc_f is legal to fetch
//   adel_f_o            : fetch address error (misaligned or outside instruction memory)
//   redirect_pending_o  : a redirect is buffered waiting for fetch to advance
module pc_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(DEF_RESET_ADDR),
    parameter logic [ADDR_W-1:0] EXC_ADDR   = ADDR_W'(DEF_EXC_ADDR),
    parameter logic [ADDR_W-1:0] IMEM_LO    = ADDR_W'(DEF_IMEM_LO),
    parameter logic [ADDR_W-1:0] IMEM_HI    = ADDR_W'(DEF_IMEM_HI)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              imem_ready_i,
    input  logic [2:0]        npc_sel_i,
    input  logic [ADDR_W-1:0] pc_d_i,
    input  logic [15:0]       imm16_i,
    input  logic [25:0]       instr_index_i,
    input  logic [ADDR_W-1:0] rs_val_i,
    input  logic              exc_req_i,
    input  logic              eret_req_i,
    input  logic [ADDR_W-1:0] epc_i,
    output logic [ADDR_W-1:0] pc_f_o,
    output logic              fetch_valid_o,
    output logic              adel_f_o,
    output logic              redirect_pending_o
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_f_q, pc_f_d, pend_q, pend_d, target;
    logic              redirect, adv;

    npc_calc #(.ADDR_W(ADDR_W)) u_npc (
        .pc_f_i        (pc_f_q),
        .pc_d_i        (pc_d_i),
        .imm16_i       (imm16_i),
        .instr_index_i (instr_index_i),
        .rs_val_i      (rs_val_i),
        .npc_sel_i     (npc_sel_i),
        .target_o      (target),
        .redirect_o    (redirect)
    );

    assign adv = !stall_i && imem_ready_i;

    // In RUN the mux output is already pc_f+4 when no redirect is selected.
    // In HOLD a fresh redirect supersedes the buffered one on the advancing cycle.
    always_comb begin
        state_d = state_q;
        pc_f_d  = pc_f_q;
        pend_d  = pend_q;
        if (exc_req_i) begin
            pc_f_d  = EXC_ADDR;
            state_d = RUN;
        end else if (eret_req_i) begin
            pc_f_d  = epc_i;
            state_d = RUN;
        end else if (state_q == RUN) begin
            if (adv) pc_f_d = target;
            else if (redirect) begin
                pend_d  = target;
                state_d = HOLD;
            end
        end else if (adv) begin
            pc_f_d  = redirect ? target : pend_q;
            state_d = RUN;
        end else if (redirect) pend_d = target;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_f_q  <= RESET_ADDR;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_f_q  <= pc_f_d;
            pend_q  <= pend_d;
        end
    end

    assign pc_f_o             = pc_f_q;
    assign redirect_pending_o = state_q == HOLD;
    assign adel_f_o           = pc_f_q[1:0] != 2'b00 || pc_f_q < IMEM_LO || pc_f_q > IMEM_HI;
    assign fetch_valid_o      = !adel_f_o && !reset;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: table-driven self-checking bench for pc_unit.
module tb_pc_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall, imem_ready, exc_req, eret_req;
    logic [2:0]  npc_sel;
    logic [31:0] pc_d, rs_val, epc, pc_f;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic        fetch_valid, adel_f, redirect_pending;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic        stall, ready;
        logic [2:0]  sel;
        logic [31:0] pcd;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] rs;
        logic        exc, eret;
        logic [31:0] epc;
        logic [31:0] exp_pc;
        logic        exp_pend, exp_adel;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    pc_unit dut (
        .clk                (clk),
        .reset              (reset),
        .stall_i            (stall),
        .imem_ready_i       (imem_ready),
        .npc_sel_i          (npc_sel),
        .pc_d_i             (pc_d),
        .imm16_i            (imm16),
        .instr_index_i      (instr_index),
        .rs_val_i           (rs_val),
        .exc_req_i          (exc_req),
        .eret_req_i         (eret_req),
        .epc_i              (epc),
        .pc_f_o             (pc_f),
        .fetch_valid_o      (fetch_valid),
        .adel_f_o           (adel_f),
        .redirect_pending_o (redirect_pending)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic st, input logic rd, input logic [2:0] sel,
                       input logic [31:0] pcd, input logic [15:0] imm, input logic [25:0] idx,
                       input logic [31:0] rs, input logic ex, input logic er, input logic [31:0] ep,
                       input logic [31:0] xpc, input logic xpend, input logic xadel);
        vec_t v;
        v = '{name, st, rd, sel, pcd, imm, idx, rs, ex, er, ep, xpc, xpend, xadel};
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        stall = v.stall; imem_ready = v.ready; npc_sel = v.sel; pc_d = v.pcd; imm16 = v.imm;
        instr_index = v.idx; rs_val = v.rs; exc_req = v.exc; eret_req = v.eret; epc = v.epc;
    endtask

    task automatic check_state(input string name, input logic [31:0] xpc, input logic xpend,
                               input logic xadel, input logic xfv);
        chk({name, ".pc_f"}, pc_f, xpc);
        chk({name, ".pending"}, 32'(redirect_pending), 32'(xpend));
        chk({name, ".adel_f"}, 32'(adel_f), 32'(xadel));
        chk({name, ".fetch_valid"}, 32'(fetch_valid), 32'(xfv));
    endtask

    initial begin
        //  name          st rd sel     pc_d       imm       idx        rs          ex er epc        exp_pc     pend adel
        add("seq1",       0, 1, 3'b000, 0,         0,        0,         0,          0, 0, 0,         32'h3004, 0, 0);
        add("seq2",       0, 1, 3'b000, 0,         0,        0,         0,          0, 0, 0,         32'h3008, 0, 0);
        add("seq3",       0, 1, 3'b000, 0,         0,        0,         0,          0, 0, 0,         32'h300C, 0, 0);
        add("branch",     0, 1, 3'b001, 32'h3010,  16'hFFFE, 0,         0,          0, 0, 0,         32'h300C, 0, 0);
        add("j_stall",    1, 1, 3'b010, 32'h3020,  0,        26'h0C10,  0,          0, 0, 0,         32'h300C, 1, 0);
        add("j_release",  0, 1, 3'b000, 0,         0,        0,         0,          0, 0, 0,         32'h3040, 0, 0);
        add("j_stall2",   1, 1, 3'b010, 32'h3020,  0,        26'h0C10,  0,          0, 0, 0,         32'h3040, 1, 0);
        add("exc_hold",   1, 1, 3'b000, 0,         0,        0,         0,          1, 0, 0,         32'h4180, 0, 0);
        add("jr_misal",   0, 1, 3'b011, 0,         0,        0,         32'h3002,   0, 0, 0,         32'h3002, 0, 1);
        add("jr_range",   0, 1, 3'b011, 0,         0,        0,         32'h7000,   0, 0, 0,         32'h7000, 0, 1);
        add("exc_eret",   0, 1, 3'b000, 0,         0,        0,         0,          1, 1, 32'h3100,  32'h4180, 0, 0);
        add("eret",       1, 0, 3'b000, 0,         0,        0,         0,          0, 1, 32'h3100,  32'h3100, 0, 0);
        add("hold_a",     1, 1, 3'b011, 0,         0,        0,         32'h3200,   0, 0, 0,         32'h3100, 1, 0);
        add("hold_last",  0, 0, 3'b011, 0,         0,        0,         32'h3300,   0, 0, 0,         32'h3100, 1, 0);
        add("hold_idle",  1, 0, 3'b000, 0,         0,        0,         0,          0, 0, 0,         32'h3100, 1, 0);
        add("hold_drain", 0, 1, 3'b000, 0,         0,        0,         0,          0, 0, 0,         32'h3300, 0, 0);
        add("hold_b",     1, 1, 3'b011, 0,         0,        0,         32'h3400,   0, 0, 0,         32'h3300, 1, 0);
        add("hold_new",   0, 1, 3'b011, 0,         0,        0,         32'h3500,   0, 0, 0,         32'h3500, 0, 0);
        add("not_ready",  0, 0, 3'b000, 0,         0,        0,         0,          0, 0, 0,         32'h3500, 0, 0);
        add("sel_1xx",    0, 1, 3'b110, 32'h5000,  16'h0010, 26'h1,     32'h5000,   0, 0, 0,         32'h3504, 0, 0);
        add("jr_top",     0, 1, 3'b011, 0,         0,        0,         32'hFFFFFFFC,0,0, 0,         32'hFFFFFFFC, 0, 1);
        add("wrap",       0, 1, 3'b000, 0,         0,        0,         0,          0, 0, 0,         32'h0000_0000, 0, 1);
        add("jr_back",    0, 1, 3'b011, 0,         0,        0,         32'h6FFC,   0, 0, 0,         32'h6FFC, 0, 0);
        add("eret_hold",  1, 1, 3'b011, 0,         0,        0,         32'h3600,   0, 0, 0,         32'h6FFC, 1, 0);
        add("eret_clr",   1, 1, 3'b000, 0,         0,        0,         0,          0, 1, 32'h3800,  32'h3800, 0, 0);

        reset = 1'b1;
        drive(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 32'h3000, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check_state("post_reset", 32'h3000, 1'b0, 1'b0, 1'b1);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_state(vecs[i].name, vecs[i].exp_pc, vecs[i].exp_pend, vecs[i].exp_adel, !vecs[i].exp_adel);
        end

        // Reset in the middle of HOLD must drop the buffered target.
        drive('{"", 1, 1, 3'b011, 0, 0, 0, 32'h3400, 0, 0, 0, 0, 0, 0});
        @(posedge clk);
        #1;
        check_state("mid_hold", 32'h3800, 1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_state("reset_hold", 32'h3000, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        drive('{"", 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        @(posedge clk);
        #1;
        check_state("after_reset", 32'h3004, 1'b0, 1'b0, 1'b1);

        // Input changes must not reach pc_f before the clock edge.
        drive('{"", 0, 1, 3'b011, 0, 0, 0, 32'h5000, 0, 0, 0, 0, 0, 0});
        #2;
        chk("no_comb_path", pc_f, 32'h3004);
        @(posedge clk);
        #1;
        chk("jr_latency", pc_f, 32'h5000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
